// File: rtl/log_delta_convert_pipe.sv
// log_delta_convert_pipe
//
// Three-stage pipelined converter between a linear significand fraction and
// its log2 fraction, for the log-domain number path.
//   mode 0 : out = round(log2(1 + f) * 2^OUT_W)       (linear -> log)
//   mode 1 : out = round((2^f - 1) * 2^OUT_W)          (log -> linear)
// with f = in_frac / 2^IN_W. The truncated input t = in_frac >> (IN_W-OUT_W)
// is corrected by a small delta from one of two ROMs that are computed at
// elaboration time from the parameters.
//
// Ports:
//   clock      rising-edge clock
//   resetn     synchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   block can accept a transaction this cycle
//   in_mode    0 = linear->log, 1 = log->linear
//   in_frac    input fraction [IN_W]
//   in_exp     signed exponent [EXP_W]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_frac   converted fraction [OUT_W]
//   out_exp    result exponent [EXP_W]
//   out_sat    exponent saturated on carry
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; once out_valid is raised the
// output payload stays stable until it is taken. A stage loads whenever it
// is empty or its contents move on in the same cycle, so the pipe sustains
// one transaction per cycle and a full pipe with out_ready=1 stays full.
//
// Pipeline:
//   S0  capture mode, frac, exp
//   S1  registered ROM read (D0 or D1 by mode), carry t, mode, exp
//   S2  correction arithmetic into the output register

module log_delta_convert_pipe #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 7,
    parameter int DELTA_W = 4,
    parameter int EXP_W   = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [IN_W-1:0]  in_frac,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_frac,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sat
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int DEPTH = 1 << IN_W;
    localparam int DMAX  = (1 << DELTA_W) - 1;

    // Delta between the exact rounded result and the truncated input.
    // Mode 0 delta is round(log2(1+f)*2^OUT_W) - t, mode 1 delta is
    // t - round((2^f-1)*2^OUT_W); both are non-negative by construction
    // of the curves (log2(1+f) >= f >= 2^f - 1 on [0,1)).
    function automatic int calc_delta(input int mode, input int x);
        real f;
        real v;
        int  r;
        int  t;
        f = real'(x) / real'(DEPTH);
        if (mode == 0) begin
            v = ($ln(1.0 + f) / $ln(2.0)) * real'(1 << OUT_W);
        end else begin
            v = ($exp(f * $ln(2.0)) - 1.0) * real'(1 << OUT_W);
        end
        r = int'($floor(v + 0.5));
        t = x >> SHIFT;
        return (mode == 0) ? (r - t) : (t - r);
    endfunction

    if (OUT_W > IN_W) begin : g_bad_width
        $fatal(1, "log_delta_convert_pipe: OUT_W (%0d) must not exceed IN_W (%0d)", OUT_W, IN_W);
    end

    logic [DELTA_W-1:0] rom0 [DEPTH];
    logic [DELTA_W-1:0] rom1 [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int D0 = calc_delta(0, i);
        localparam int D1 = calc_delta(1, i);
        if (D0 < 0 || D0 > DMAX || D1 < 0 || D1 > DMAX) begin : g_bad_delta
            $fatal(1, "log_delta_convert_pipe: delta at index %0d (D0=%0d, D1=%0d) does not fit DELTA_W=%0d",
                   i, D0, D1, DELTA_W);
        end
        assign rom0[i] = DELTA_W'(D0);
        assign rom1[i] = DELTA_W'(D1);
    end

    // ------------------------------------------------------------------
    // Stage enables
    // ------------------------------------------------------------------
    logic s0_valid;
    logic s1_valid;
    logic en0;
    logic en1;
    logic en2;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign en0      = !s0_valid || en1;
    assign in_ready = en0;

    // ------------------------------------------------------------------
    // S0: capture
    // ------------------------------------------------------------------
    logic             s0_mode;
    logic [IN_W-1:0]  s0_frac;
    logic [EXP_W-1:0] s0_exp;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s0_valid <= 1'b0;
            s0_mode  <= 1'b0;
            s0_frac  <= '0;
            s0_exp   <= '0;
        end else if (en0) begin
            s0_valid <= in_valid;
            s0_mode  <= in_mode;
            s0_frac  <= in_frac;
            s0_exp   <= in_exp;
        end
    end

    // ------------------------------------------------------------------
    // S1: ROM read
    // ------------------------------------------------------------------
    logic               s1_mode;
    logic [OUT_W-1:0]   s1_t;
    logic [DELTA_W-1:0] s1_delta;
    logic [EXP_W-1:0]   s1_exp;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_t     <= '0;
            s1_delta <= '0;
            s1_exp   <= '0;
        end else if (en1) begin
            s1_valid <= s0_valid;
            s1_mode  <= s0_mode;
            s1_t     <= s0_frac[IN_W-1:SHIFT];
            s1_delta <= s0_mode ? rom1[s0_frac] : rom0[s0_frac];
            s1_exp   <= s0_exp;
        end
    end

    // ------------------------------------------------------------------
    // S2: correction arithmetic
    // ------------------------------------------------------------------
    localparam logic [EXP_W-1:0] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};

    logic [OUT_W:0]   sum;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] nxt_frac;
    logic [EXP_W-1:0] nxt_exp;
    logic             nxt_sat;

    always_comb begin
        sum      = {1'b0, s1_t} + (OUT_W+1)'(s1_delta);
        diff     = s1_t - OUT_W'(s1_delta);
        nxt_frac = '0;
        nxt_exp  = s1_exp;
        nxt_sat  = 1'b0;
        if (!s1_mode) begin
            if (sum[OUT_W]) begin
                // Rounded log reached 1.0: move the unit into the exponent,
                // unless the exponent is already at its positive limit.
                if (s1_exp == EXP_MAX) begin
                    nxt_frac = '1;
                    nxt_sat  = 1'b1;
                end else begin
                    nxt_exp = s1_exp + EXP_W'(1);
                end
            end else begin
                nxt_frac = sum[OUT_W-1:0];
            end
        end else begin
            nxt_frac = diff;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_frac  <= '0;
            out_exp   <= '0;
            out_sat   <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            out_frac  <= nxt_frac;
            out_exp   <= nxt_exp;
            out_sat   <= nxt_sat;
        end
    end

endmodule

// File: tb/tb_log_delta_convert_pipe.sv
// Testbench for log_delta_convert_pipe at default parameters
// (IN_W=8, OUT_W=7, DELTA_W=4, EXP_W=8).

module tb_log_delta_convert_pipe;

    localparam int W = 16; // {frac[6:0], exp[7:0], sat}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_mode = 1'b0;
    logic [7:0] in_frac = '0;
    logic [7:0] in_exp = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_frac;
    logic [7:0] out_exp;
    logic       out_sat;

    always #5 clock = ~clock;

    log_delta_convert_pipe dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_frac   (in_frac),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frac  (out_frac),
        .out_exp   (out_exp),
        .out_sat   (out_sat)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // out_ready control: random or forced, applied on the falling edge
    bit   rdy_random = 1'b0;
    logic rdy_force  = 1'b1;

    always @(negedge clock) begin
        if (rdy_random) out_ready = 1'($urandom_range(0, 1));
        else            out_ready = rdy_force;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Real-math reference for one transaction.
    function automatic logic [W-1:0] model(input logic m, input logic [7:0] f, input logic [7:0] e);
        real fr;
        real r;
        int  q;
        fr = real'(f) / 256.0;
        if (!m) r = ($ln(1.0 + fr) / $ln(2.0)) * 128.0;
        else    r = ($exp(fr * $ln(2.0)) - 1.0) * 128.0;
        q = int'($floor(r + 0.5));
        if (!m && q >= 128) begin
            if (e == 8'h7F) return {7'h7F, e, 1'b1};
            else            return {7'h00, e + 8'd1, 1'b0};
        end
        return {7'(q), e, 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Driver: present a transaction, push its expectation when accepted.
    // Returns just after the accepting rising edge.
    // ------------------------------------------------------------------
    task automatic send(input logic m, input logic [7:0] f, input logic [7:0] e, input logic [W-1:0] want);
        bit acc;
        acc = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_mode  = m;
        in_frac  = f;
        in_exp   = e;
        for (int i = 0; i < 200 && !acc; i++) begin
            #1;
            acc = in_ready;
            if (acc) exp_q.push_back(want);
            @(posedge clock);
            if (!acc) @(negedge clock);
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for mode=%0d frac=0x%0h", m, f);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pop and compare on each output transfer, and check the
    // payload is held while the output is stalled.
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        logic [W-1:0] held;
        bit           hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!resetn) begin
                hold = 1'b0;
            end else begin
                got = {out_frac, out_exp, out_sat};
                if (hold) begin
                    check("stall_stable", {15'd0, out_valid, got}, {15'd0, 1'b1, held});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h with empty expected queue", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("result", 32'(got), 32'(want));
                    end
                end
                hold = out_valid && !out_ready;
                held = got;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        logic m;
        logic [7:0] f;
        logic [7:0] e;

        // Reset held for 3 cycles with in_valid asserted
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_frac  = 8'h80;
        in_exp   = 8'h11;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_frac",  32'(out_frac),  32'd0);
        check("reset_out_exp",   32'(out_exp),   32'd0);
        check("reset_out_sat",   32'(out_sat),   32'd0);
        resetn   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // First-result latency
        send(1'b0, 8'h01, 8'h00, {7'd1, 8'h00, 1'b0});
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (out_valid) break;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        check("first_latency", 32'(lat), 32'd3);

        // Directed mode 0 / mode 1 vectors
        send(1'b0, 8'h00, 8'h05, {7'd0,   8'h05, 1'b0});
        send(1'b0, 8'h80, 8'h00, {7'd75,  8'h00, 1'b0});
        send(1'b0, 8'hFF, 8'h03, {7'd0,   8'h04, 1'b0});
        send(1'b0, 8'hFF, 8'h7F, {7'h7F,  8'h7F, 1'b1});
        send(1'b0, 8'hFF, 8'hFF, {7'd0,   8'h00, 1'b0});
        send(1'b1, 8'h80, 8'h00, {7'd53,  8'h00, 1'b0});
        send(1'b1, 8'h00, 8'h80, {7'd0,   8'h80, 1'b0});
        send(1'b1, 8'hFF, 8'h7F, {7'd127, 8'h7F, 1'b0});

        // Exhaustive sweep in both modes
        for (int md = 0; md < 2; md++) begin
            for (int x = 0; x < 256; x++) begin
                m = 1'(md);
                f = 8'(x);
                e = 8'(x * 7);
                send(m, f, e, model(m, f, e));
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(posedge clock);

        // Backpressure: 20 alternating-mode transactions with random
        // out_ready and a 5-cycle stall window
        @(posedge clock);
        #1;
        rdy_random = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    m = 1'(i % 2);
                    f = 8'(i * 37 + 5);
                    e = 8'(i * 11 - 40);
                    send(m, f, e, model(m, f, e));
                end
                @(negedge clock);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                rdy_random = 1'b0;
                rdy_force  = 1'b0;
                repeat (5) @(negedge clock);
                #2;
                check("bp_in_ready_low", 32'(in_ready),  32'd0);
                check("bp_out_valid",    32'(out_valid), 32'd1);
                @(posedge clock);
                #1;
                rdy_random = 1'b1;
            end
        join
        @(posedge clock);
        #1;
        rdy_random = 1'b0;
        rdy_force  = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with transactions in flight drops them
        @(posedge clock);
        #1;
        rdy_force = 1'b0;
        send(1'b0, 8'h40, 8'h01, model(1'b0, 8'h40, 8'h01));
        send(1'b1, 8'h40, 8'h02, model(1'b1, 8'h40, 8'h02));
        @(negedge clock);
        in_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        resetn    = 1'b1;
        rdy_force = 1'b1;
        repeat (4) @(negedge clock);
        #2;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready",  32'(in_ready),  32'd1);

        // Pipe still works after the drop
        send(1'b0, 8'h80, 8'h09, {7'd75, 8'h09, 1'b0});
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
